capture_readout: RTL and testbench
==================================

CAPTURE_READOUT -- requirements
Module: capture_readout

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 25, sample width in bits.
REQ-002 SHALL have parameter LEN, default 512, capture depth in samples; must be a power of two, 4 to 1024.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port di, input, DATA_WIDTH signed, incoming sample.
REQ-006 SHALL have port di_valid, input, 1, di is written this cycle when high.
REQ-007 SHALL have port trig, input, 1, single-cycle capture request.
REQ-008 SHALL have port busy, output, 1, high in DRAIN state.
REQ-009 SHALL have port armed, output, 1, high in ARMED state.
REQ-010 SHALL have port dout, output, DATA_WIDTH signed, readout sample.
REQ-011 SHALL have port dout_valid, output, 1, dout holds a valid sample.
REQ-012 SHALL have port dout_ready, input, 1, sink accepts dout this cycle.
REQ-013 SHALL have port dout_last, output, 1, marks final (newest) sample of a readout.

Function
REQ-014 SHALL use three states: FILL, ARMED, DRAIN.
REQ-015 SHALL, in FILL and ARMED, write di to RAM at wr_addr and increment wr_addr modulo LEN on each cycle di_valid is high.
REQ-016 SHALL count writes in FILL with a log2(LEN)+1-bit counter and move to ARMED on the cycle the LEN-th write occurs.
REQ-017 SHALL ignore trig in FILL and DRAIN; no queuing of triggers.
REQ-018 SHALL, on trig in ARMED, move to DRAIN next cycle with rd_addr = wr_addr after any same-cycle write; a sample written with trig is the newest captured sample.
REQ-019 SHALL ignore di_valid in DRAIN; no writes, wr_addr frozen.
REQ-020 SHALL present exactly LEN samples in DRAIN, oldest first, rd_addr incrementing modulo LEN.
REQ-021 SHALL transfer a sample on every cycle dout_valid and dout_ready are both high.
REQ-022 SHALL hold dout, dout_last stable and dout_valid high until transfer.
REQ-023 SHALL assert dout_valid no earlier than 2 cycles after trig: 1 cycle state change, 1 cycle RAM read latency.
REQ-024 SHALL sustain one transfer per cycle with dout_ready held high, no bubbles after the first sample.
REQ-025 SHALL assert dout_last with the LEN-th sample only.
REQ-026 SHALL, on the cycle the LEN-th sample transfers, return to FILL with fill counter cleared; wr_addr keeps its value.
REQ-027 SHALL not alter RAM contents during DRAIN.

Reset
REQ-028 SHALL, on rst high at a clock edge, set state FILL, wr_addr 0, rd_addr 0, fill counter 0.
REQ-029 SHALL drive dout_valid 0, dout_last 0, busy 0, armed 0 the cycle after rst; dout value 0.
REQ-030 SHALL abort a readout when rst is asserted mid-DRAIN, with no further transfers.
REQ-031 SHALL not initialise RAM contents; reset does not clear memory.

Structure
REQ-032 SHALL place state encoding and the LEN legality check in a shared package, capture_readout_pkg.
REQ-033 SHALL instantiate one sub-module, sdp_ram: simple dual-port, 1-cycle registered read, inferable as block RAM.
REQ-034 SHALL use a 2-entry output skid buffer to keep RAM read latency hidden under backpressure.

Verification (LEN=8, DATA_WIDTH=25)
REQ-035 SHALL cover: reset, then di=1..8 valid every cycle -> armed high the cycle after the 8th write.
REQ-036 SHALL cover: di=1..12 then trig with no same-cycle write, dout_ready=1 -> dout=5,6,...,12 on consecutive cycles, dout_last with 12, then state FILL.
REQ-037 SHALL cover: trig in the same cycle as a valid di=13 after 1..12 -> readout 6..13.
REQ-038 SHALL cover: dout_ready toggling 1,0,0,1 through the readout -> all 8 samples in order, none duplicated or lost, dout stable while stalled.
REQ-039 SHALL cover: trig during FILL (only 5 writes) -> ignored, busy stays 0; di_valid during DRAIN -> readout contents unchanged.
REQ-040 SHALL cover: rst asserted after the 3rd transfer -> dout_valid 0 next cycle, state FILL, a later full fill and trig give a correct 8-sample readout.

Source files
------------

// File: rtl/capture_readout_pkg.sv
// Shared types and parameter checks for the capture/readout buffer.
package capture_readout_pkg;

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StArmed = 2'd1,
        StDrain = 2'd2
    } state_e;

    function automatic bit len_is_legal(input int unsigned len);
        return (len >= 4) && (len <= 1024) && ((len & (len - 1)) == 0);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_ram #(
    parameter int unsigned DataWidth = 25,
    parameter int unsigned Depth     = 512,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_readout.sv
// Circular capture buffer: fills continuously, freezes on trigger, then streams out
// the LEN most recent samples oldest-first over a valid/ready interface.
module capture_readout
    import capture_readout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 25,
    parameter int unsigned LEN        = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] di,
    input  logic                         di_valid,
    input  logic                         trig,
    output logic                         busy,
    output logic                         armed,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         dout_last
);

    localparam int unsigned AW = $clog2(LEN);
    localparam logic [AW:0] LenCnt  = LEN[AW:0];
    localparam logic [AW:0] LenLast = LenCnt - 1'b1;

    if (!len_is_legal(LEN)) begin : g_len_check
        $error("capture_readout: LEN must be a power of two in [4,1024]");
    end

    state_e                state_q, state_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [AW:0]           fill_cnt_q, fill_cnt_d;
    logic [AW:0]           issue_cnt_q, issue_cnt_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  ram_last_q, ram_last_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic                  buf0_last_q, buf0_last_d, buf1_last_q, buf1_last_d;

    logic                  we, re, push, pop, start_drain;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] ram_rdata;

    sdp_ram #(
        .DataWidth(DATA_WIDTH),
        .Depth    (LEN)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (we),
        .waddr_i(wr_addr_q),
        .wdata_i(di),
        .re_i   (re),
        .raddr_i(rd_addr_q),
        .rdata_o(ram_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (we && (fill_cnt_q == LenLast)) state_d = StArmed;
            StArmed: if (trig) state_d = StDrain;
            StDrain: if (pop && buf0_last_q) state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q == StDrain);
        armed      = (state_q == StArmed);
        dout_valid = (buf_cnt_q != 2'd0);
        dout       = buf0_q;
        dout_last  = buf0_last_q && dout_valid;
    end

    // Datapath: write side, read issue, and the two-entry skid buffer
    always_comb begin
        we          = di_valid && (state_q != StDrain);
        start_drain = (state_q == StArmed) && trig;
        pop         = (buf_cnt_q != 2'd0) && dout_ready;
        push        = ram_vld_q;
        // Issue only if the word it returns is guaranteed a buffer slot.
        occ         = {1'b0, buf_cnt_q} + {2'b00, ram_vld_q} - {2'b00, pop};
        re          = (state_q == StDrain) && (issue_cnt_q != LenCnt) && (occ <= 3'd1);

        wr_addr_d   = we ? wr_addr_q + 1'b1 : wr_addr_q;

        fill_cnt_d  = fill_cnt_q;
        if ((state_q == StFill) && we) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
        end else if ((state_q == StDrain) && (state_d == StFill)) begin
            fill_cnt_d = '0;
        end

        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        if (start_drain) begin
            rd_addr_d   = wr_addr_d;
            issue_cnt_d = '0;
        end else if (re) begin
            rd_addr_d   = rd_addr_q + 1'b1;
            issue_cnt_d = issue_cnt_q + 1'b1;
        end

        ram_vld_d   = re;
        ram_last_d  = re && (issue_cnt_q == LenLast);

        buf_cnt_d   = buf_cnt_q + {1'b0, push} - {1'b0, pop};
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        buf0_last_d = buf0_last_q;
        buf1_last_d = buf1_last_q;
        case ({push, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_d      = ram_rdata;
                    buf0_last_d = ram_last_q;
                end else begin
                    buf1_d      = ram_rdata;
                    buf1_last_d = ram_last_q;
                end
            end
            2'b01: begin
                buf0_d      = buf1_q;
                buf0_last_d = buf1_last_q;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d      = ram_rdata;
                    buf0_last_d = ram_last_q;
                end else begin
                    buf0_d      = buf1_q;
                    buf0_last_d = buf1_last_q;
                    buf1_d      = ram_rdata;
                    buf1_last_d = ram_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            fill_cnt_q  <= '0;
            issue_cnt_q <= '0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            buf_cnt_q   <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            buf0_last_q <= 1'b0;
            buf1_last_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            ram_vld_q   <= ram_vld_d;
            ram_last_q  <= ram_last_d;
            buf_cnt_q   <= buf_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            buf0_last_q <= buf0_last_d;
            buf1_last_q <= buf1_last_d;
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout (LEN=8): vector table, directed corner sequences, and a
// random run checked against a sample-history model.
module tb_capture_readout;

    localparam int DW  = 25;
    localparam int LEN = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] di = '0;
    logic                 di_valid = 1'b0;
    logic                 trig = 1'b0;
    logic                 busy, armed, dout_valid, dout_last;
    logic signed [DW-1:0] dout;
    logic                 dout_ready = 1'b0;

    always #5 clk = ~clk;

    capture_readout #(
        .DATA_WIDTH(DW),
        .LEN       (LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .di        (di),
        .di_valid  (di_valid),
        .trig      (trig),
        .busy      (busy),
        .armed     (armed),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          t;
        logic          exp_armed;
        logic          exp_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: mode 0 filling, 1 armed, 2 draining.
    int            m_mode = 0;
    int            m_n    = 0;
    logic [DW-1:0] hist[$];
    logic [DW-1:0] expq[$];
    logic [DW-1:0] got[$];
    int            xfer_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_n    = 0;
        hist.delete();
        expq.delete();
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic t, input logic r);
        logic          xfer, stall, xl;
        logic [DW-1:0] xd, e;
        int            m0;
        di_valid   = v;
        di         = d;
        trig       = t;
        dout_ready = r;
        xfer  = dout_valid && r;
        stall = dout_valid && !r;
        xd    = dout;
        xl    = dout_last;
        m0    = m_mode;
        if (m0 != 2 && v) hist.push_back(d);
        if (m0 == 0 && v) begin
            m_n++;
            if (m_n == LEN) m_mode = 1;
        end
        if (m0 == 1 && t) begin
            expq.delete();
            for (int i = hist.size() - LEN; i < hist.size(); i++) expq.push_back(hist[i]);
            m_mode = 2;
        end
        if (xfer) begin
            got.push_back(xd);
            xfer_cyc.push_back(cyc);
            if (m0 != 2 || expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got dout %0d outside a readout (cycle %0d)",
                         xd, cyc);
            end else begin
                e = expq.pop_front();
                chk("dout", {7'b0, xd}, {7'b0, e});
                chk1("dout_last", xl, expq.size() == 0);
                if (expq.size() == 0) begin
                    m_mode = 0;
                    m_n    = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk1("busy", busy, m_mode == 2);
        chk1("armed", armed, m_mode == 1);
        if (m_mode != 2) chk1("idle_dout_valid", dout_valid, 1'b0);
        if (stall) begin
            chk1("stall_valid", dout_valid, 1'b1);
            chk("stall_dout", {7'b0, dout}, {7'b0, xd});
            chk1("stall_last", dout_last, xl);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        di_valid   = 1'b0;
        trig       = 1'b0;
        dout_ready = 1'b0;
        di         = '0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_reset();
        chk1("rst_dout_valid", dout_valid, 1'b0);
        chk1("rst_dout_last", dout_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_armed", armed, 1'b0);
        chk("rst_dout", {7'b0, dout}, 32'd0);
    endtask

    task automatic fill(input int first, input int count);
        for (int i = 0; i < count; i++) cycle(1'b1, DW'(first + i), 1'b0, 1'b1);
    endtask

    // pat: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic drain(input int pat, input bit junk, input int stop_after);
        int   k;
        int   start;
        logic r;
        k     = 0;
        start = xfer_cyc.size();
        while (m_mode == 2) begin
            if (k == 200) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d transfers expected %0d",
                         xfer_cyc.size() - start, LEN);
                break;
            end
            if (stop_after > 0 && xfer_cyc.size() - start >= stop_after) break;
            if (pat == 0) r = 1'b1;
            else if (pat == 1) r = ((k % 4) == 0) || ((k % 4) == 3);
            else r = 1'($urandom_range(0, 1));
            if (junk) cycle(1'($urandom_range(0, 1)), DW'($urandom()),
                            1'($urandom_range(0, 1)), r);
            else cycle(1'b0, '0, 1'b0, r);
            k++;
        end
    endtask

    task automatic chk_seq(input string name, input int x0, input int first);
        chk({name, "_count"}, 32'(got.size() - x0), 32'(LEN));
        for (int k = 0; k < LEN && x0 + k < got.size(); k++)
            chk(name, {7'b0, got[x0 + k]}, 32'(first + k));
    endtask

    initial begin
        vec_t tbl[9];
        int   x0;

        do_reset();

        // Fill 1..8 with a trigger during fill that must be ignored.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{v: 1'b1, d: DW'(i + 1), t: (i == 3), exp_armed: (i == 7), exp_busy: 1'b0};
        tbl[8] = '{v: 1'b0, d: '0, t: 1'b0, exp_armed: 1'b1, exp_busy: 1'b0};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].t, 1'b1);
            chk1("tbl_armed", armed, tbl[i].exp_armed);
            chk1("tbl_busy", busy, tbl[i].exp_busy);
        end

        // 1..12 then trigger without a write: 5..12 with no bubbles.
        fill(9, 4);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk1("trig_latency", dout_valid, 1'b0);
        x0 = got.size();
        drain(0, 1'b0, 0);
        chk_seq("seq_5_12", x0, 5);
        for (int k = 1; k < LEN && x0 + k < xfer_cyc.size(); k++)
            chk("no_bubble", 32'(xfer_cyc[x0 + k] - xfer_cyc[x0]), 32'(k));
        chk1("back_to_fill", busy | armed, 1'b0);

        // Trigger with a same-cycle write of 13 after 1..12: 6..13.
        fill(1, 12);
        cycle(1'b1, DW'(13), 1'b1, 1'b1);
        x0 = got.size();
        drain(0, 1'b0, 0);
        chk_seq("seq_6_13", x0, 6);

        // Backpressure pattern 1,0,0,1.
        fill(21, 8);
        cycle(1'b0, '0, 1'b1, 1'b0);
        x0 = got.size();
        drain(1, 1'b0, 0);
        chk_seq("seq_stall", x0, 21);

        // Writes and triggers during readout must not disturb it.
        fill(31, 8);
        cycle(1'b0, '0, 1'b1, 1'b1);
        x0 = got.size();
        drain(2, 1'b1, 0);
        chk_seq("seq_junk", x0, 31);

        // Reset after the third transfer aborts, then a fresh capture works.
        fill(41, 8);
        cycle(1'b0, '0, 1'b1, 1'b1);
        drain(0, 1'b0, 3);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        fill(51, 8);
        cycle(1'b0, '0, 1'b1, 1'b1);
        x0 = got.size();
        drain(0, 1'b0, 0);
        chk_seq("seq_after_rst", x0, 51);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 1)), DW'($urandom()),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
